// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream valid/ready/data, downstream
// valid/ready/data, hazard flush and occupancy.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 115
);
    logic              FLUSH;
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [DATA_W-1:0] OUT_DATA;
    logic [1:0]        LEVEL;

    modport slave (
        input  FLUSH, IN_VALID, IN_DATA, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, LEVEL
    );

    modport master (
        output FLUSH, IN_VALID, IN_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, LEVEL
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and flush.
// Define PIPE_SKID_EN to add a second (skid) entry and a registered IN_READY.
module pipe_stage_skid #(
    parameter int DATA_W = 115
) (
    input  logic              CLOCK,
    input  logic              RESET,
    pipe_stage_skid_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              main_v_q, main_v_d;
    logic              in_ready, in_fire, out_fire;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              skid_v_q, skid_v_d;
    logic              in_ready_q, in_ready_d;

    // Ready depends only on held state, so OUT_READY never reaches IN_READY.
    assign in_ready = in_ready_q;
`else
    assign in_ready = !main_v_q | bus.OUT_READY;
`endif

    assign in_fire  = bus.IN_VALID & in_ready;
    assign out_fire = main_v_q & bus.OUT_READY;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        main_v_d = main_v_q;
`ifdef PIPE_SKID_EN
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
`endif
        if (bus.FLUSH) begin
            // Any input accepted this cycle is dropped along with held entries.
            state_d  = EMPTY;
            main_d   = '0;
            main_v_d = 1'b0;
`ifdef PIPE_SKID_EN
            skid_d   = '0;
            skid_v_d = 1'b0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d   = bus.IN_DATA;
                        main_v_d = 1'b1;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.IN_DATA;
`ifdef PIPE_SKID_EN
                    end else if (in_fire) begin
                        skid_d   = bus.IN_DATA;
                        skid_v_d = 1'b1;
                        state_d  = FULL;
`endif
                    end else if (out_fire) begin
                        main_d   = '0;
                        main_v_d = 1'b0;
                        state_d  = EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                FULL: begin
                    if (out_fire) begin
                        main_d   = skid_q;
                        skid_d   = '0;
                        skid_v_d = 1'b0;
                        state_d  = BUSY;
                    end
                end
`endif
                default: begin
                    state_d  = EMPTY;
                    main_d   = '0;
                    main_v_d = 1'b0;
                end
            endcase
        end
`ifdef PIPE_SKID_EN
        in_ready_d = (state_d != FULL);
`endif
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            main_v_q   <= 1'b0;
`ifdef PIPE_SKID_EN
            skid_q     <= '0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            main_v_q   <= main_v_d;
`ifdef PIPE_SKID_EN
            skid_q     <= skid_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
`endif
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = main_v_q;
    // main_q is zeroed whenever it goes invalid, so bubbles carry no controls.
    assign bus.OUT_DATA  = main_q;
`ifdef PIPE_SKID_EN
    assign bus.LEVEL     = state_q;
`else
    assign bus.LEVEL     = {1'b0, state_q == BUSY};
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and soak bench for pipe_stage_skid; follows PIPE_SKID_EN if defined.
module tb_pipe_stage_skid;
    localparam int DATA_W = 115;

    logic CLOCK;
    logic RESET;
    int   n_chk;
    int   n_err;

    pipe_stage_skid_if #(.DATA_W(DATA_W)) bus ();

    pipe_stage_skid #(.DATA_W(DATA_W)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                           input logic [1:0] lvl);
        chk({tag, "_valid"}, 128'(bus.OUT_VALID), 128'(v));
        chk({tag, "_data"},  128'(bus.OUT_DATA),  128'(d));
        chk({tag, "_level"}, 128'(bus.LEVEL),     128'(lvl));
    endtask

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] cur, exp_d;
    logic [127:0]      r;
    logic              hold, ordy, fl, iv, rdy, exp_rdy;
    logic [1:0]        A_LVL;

    initial begin
        n_chk = 0;
        n_err = 0;
        RESET = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.IN_VALID  = 1'b1;
        bus.IN_DATA   = '1;
        bus.OUT_READY = 1'b0;

        // reset held with a live all-ones offer
        repeat (3) begin
            tick();
            chk_out("rst", 1'b0, '0, 2'd0);
            chk("rst_in_ready", 128'(bus.IN_READY), 128'(1));
        end
        RESET = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = '0;
        tick();
        chk_out("idle", 1'b0, '0, 2'd0);

        // streaming
        bus.OUT_READY = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = DATA_W'(i);
            #1;
            chk("stream_in_ready", 128'(bus.IN_READY), 128'(1));
            tick();
            chk_out("stream", 1'b1, DATA_W'(i), 2'd1);
        end
        bus.IN_VALID = 1'b0;
        tick();
        chk_out("stream_drain", 1'b0, '0, 2'd0);

        // backpressure
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = DATA_W'(32'hA);
        tick();
        chk_out("bp_a", 1'b1, DATA_W'(32'hA), 2'd1);
        bus.OUT_READY = 1'b0;
        bus.IN_DATA   = DATA_W'(32'hB);
        #1;
`ifdef PIPE_SKID_EN
        chk("bp_skid_ready", 128'(bus.IN_READY), 128'(1));
        tick();
        chk_out("bp_full", 1'b1, DATA_W'(32'hA), 2'd2);
        chk("bp_full_ready", 128'(bus.IN_READY), 128'(0));
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        tick();
        chk_out("bp_b", 1'b1, DATA_W'(32'hB), 2'd1);
        chk("bp_b_ready", 128'(bus.IN_READY), 128'(1));
`else
        chk("bp_stall_ready", 128'(bus.IN_READY), 128'(0));
        tick();
        chk_out("bp_hold", 1'b1, DATA_W'(32'hA), 2'd1);
        chk("bp_hold_ready", 128'(bus.IN_READY), 128'(0));
        bus.OUT_READY = 1'b1;
        #1;
        chk("bp_release_ready", 128'(bus.IN_READY), 128'(1));
        tick();
        chk_out("bp_b", 1'b1, DATA_W'(32'hB), 2'd1);
        bus.IN_VALID = 1'b0;
`endif
        tick();
        chk_out("bp_drain", 1'b0, '0, 2'd0);

        // flush with held entries and a coincident offer
        bus.OUT_READY = 1'b0;
        bus.IN_VALID  = 1'b1;
        bus.IN_DATA   = DATA_W'(32'hA);
        tick();
`ifdef PIPE_SKID_EN
        bus.IN_DATA = DATA_W'(32'hB);
        tick();
        A_LVL = 2'd2;
`else
        A_LVL = 2'd1;
`endif
        chk_out("fl_pre", 1'b1, DATA_W'(32'hA), A_LVL);
        bus.FLUSH   = 1'b1;
        bus.IN_DATA = DATA_W'(32'hC);
        tick();
        bus.FLUSH    = 1'b0;
        bus.IN_VALID = 1'b0;
        chk_out("fl_post", 1'b0, '0, 2'd0);
        #1;
        chk("fl_in_ready", 128'(bus.IN_READY), 128'(1));
        tick();
        chk_out("fl_no_c", 1'b0, '0, 2'd0);

        // asynchronous reset between edges
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = DATA_W'(32'h7);
        tick();
        bus.IN_VALID = 1'b0;
        chk_out("ar_busy", 1'b1, DATA_W'(32'h7), 2'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk_out("ar_low", 1'b0, '0, 2'd0);
        chk("ar_in_ready", 128'(bus.IN_READY), 128'(1));
        #2;
        RESET = 1'b1;
        tick();
        chk_out("ar_rel", 1'b0, '0, 2'd0);
        bus.IN_VALID  = 1'b1;
        bus.IN_DATA   = DATA_W'(32'h5);
        bus.OUT_READY = 1'b1;
        tick();
        chk_out("ar_five", 1'b1, DATA_W'(32'h5), 2'd1);
        bus.IN_VALID = 1'b0;
        tick();
        chk_out("ar_drain", 1'b0, '0, 2'd0);

        // random soak against a FIFO model
        hold = 1'b0;
        cur  = '0;
        iv   = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            exp_d = (q.size() > 0) ? q[0] : '0;
            chk("soak_valid", 128'(bus.OUT_VALID), 128'(q.size() > 0));
            chk("soak_data",  128'(bus.OUT_DATA),  128'(exp_d));
            chk("soak_level", 128'(bus.LEVEL),     128'(q.size()));
            if (!hold) begin
                r   = {$urandom, $urandom, $urandom, $urandom};
                cur = r[DATA_W-1:0];
                iv  = ($urandom_range(0, 99) < 70);
            end
            ordy = ($urandom_range(0, 99) < 55);
            fl   = ($urandom_range(0, 99) == 0);
            bus.IN_VALID  = iv;
            bus.IN_DATA   = cur;
            bus.OUT_READY = ordy;
            bus.FLUSH     = fl;
            #1;
            rdy = bus.IN_READY;
`ifdef PIPE_SKID_EN
            exp_rdy = (q.size() < 2);
`else
            exp_rdy = (q.size() == 0) || ordy;
`endif
            chk("soak_in_ready", 128'(rdy), 128'(exp_rdy));
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (fl) q.delete();
            else if (iv && rdy) q.push_back(cur);
            hold = iv && !rdy;
            tick();
        end
        bus.FLUSH = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake and an optional two-entry skid buffer. It is the generic successor of the fixed-field stage registers between pipeline stages. The stall input is replaced by downstream backpressure (OUT_READY). The flush input zeroes every held entry. Any stage boundary instantiates it with the bundle width it needs, e.g. ID/EXE, EXE/MEM or MEM/WB.

## Interface
- DATA_W, 115: width of the stage bundle. 115 is the ID/EXE bundle: operands, ALU control, shift amount, memory write data and controls, write register and enable. Legal values are 1 and up.
- CLOCK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-low reset
- FLUSH  input  1  synchronous flush from the hazard unit; highest priority after RESET
- IN_VALID  input  1  upstream has a bundle on IN_DATA
- IN_READY  output  1  stage accepts IN_DATA this cycle
- IN_DATA  input  DATA_W  upstream bundle
- OUT_VALID  output  1  OUT_DATA holds a valid bundle
- OUT_READY  input  1  downstream consumes OUT_DATA this cycle
- OUT_DATA  output  DATA_W  bundle toward the next stage; all-zero when OUT_VALID=0
- LEVEL  output  2  occupancy: 0, 1 or 2 entries

## Operation
- Storage:
  - main entry (main_q, main_v) drives OUT_DATA/OUT_VALID directly; no combinational path from IN_DATA to OUT_DATA.
  - skid entry (skid_q, skid_v) exists only with the skid buffer compiled in.
- Transfers:
  - in_fire = IN_VALID & IN_READY
  - out_fire = OUT_VALID & OUT_READY
- States: EMPTY (LEVEL 0), BUSY (LEVEL 1), FULL (LEVEL 2).
- EMPTY:
  - in_fire: main <= IN_DATA, go to BUSY.
  - otherwise stay.
- BUSY:
  - in_fire & out_fire: main <= IN_DATA, stay in BUSY.
  - in_fire & !out_fire: skid <= IN_DATA, go to FULL.
  - !in_fire & out_fire: main <= 0, go to EMPTY.
  - otherwise hold.
- FULL:
  - IN_READY=0.
  - out_fire: main <= skid, skid <= 0, go to BUSY.
  - otherwise hold.
- FLUSH=1:
  - next state is EMPTY and main/skid data and valids are zeroed, regardless of in_fire or out_fire that cycle.
  - An in_fire coinciding with FLUSH is discarded.
  - out_fire in the flush cycle still counts as consumed by downstream.
- Ordering: strict FIFO. The skid entry is always older than any later input.
- Bubbles: an empty stage outputs all-zero data, so downstream control fields (write enable, mem read/write) are deasserted.

## Timing
- RESET low (asynchronous): OUT_VALID=0, OUT_DATA=0, LEVEL=0, IN_READY=1, skid cleared.
- RESET release: operation starts at the first rising CLOCK with RESET high.
- Latency: one cycle. A bundle accepted on edge N appears on OUT_DATA after edge N.
- Throughput: one bundle per cycle while OUT_READY=1.
- Skid compiled in:
  - IN_READY = (state != FULL), a register output. No combinational path from OUT_READY to IN_READY.
  - One extra bundle is absorbed after OUT_READY drops.
- Reset mid-operation: all entries are lost immediately and outputs go to reset values without waiting for a clock.
- FLUSH with OUT_READY=0 in FULL: both entries are dropped; LEVEL=0 and IN_READY=1 after the edge.
- Upstream rule: IN_VALID/IN_DATA must be held stable until in_fire. The stage does not check this.

## Configuration
- PIPE_SKID_EN defined:
  - two-entry behaviour as above.
  - IN_READY registered.
  - LEVEL ranges 0 to 2.
- PIPE_SKID_EN undefined:
  - skid entry removed; FULL unreachable.
  - IN_READY = !main_v | OUT_READY (combinational).
  - LEVEL ranges 0 to 1; LEVEL[1] tied 0.
  - latency, flush and reset behaviour unchanged.

## Test plan
- Reset: hold RESET=0 with IN_VALID=1, IN_DATA=all-ones -> OUT_VALID=0, OUT_DATA=0, LEVEL=0, IN_READY=1 throughout.
- Streaming: OUT_READY=1; bundles 0x1, 0x2, 0x3 on consecutive cycles -> each appears on OUT_DATA one cycle after its acceptance; LEVEL stays 1; IN_READY stays 1.
- Backpressure (skid build):
  - Accept 0xA, drop OUT_READY, offer 0xB -> LEVEL=2, IN_READY=0, OUT_DATA=0xA held.
  - Raise OUT_READY -> outputs 0xA then 0xB; LEVEL returns 1 then 0.
  - Non-skid build: the same stimulus leaves 0xB waiting upstream until 0xA is consumed.
- Flush while FULL with entries 0xA, 0xB and IN_VALID=1, IN_DATA=0xC -> next cycle LEVEL=0, OUT_VALID=0, OUT_DATA=0; 0xC is not captured.
- Async reset mid-stream: pulse RESET low between clock edges while in BUSY -> OUT_VALID falls before the next edge. After release, the first new bundle 0x5 comes out with latency 1.
- Random soak: random IN_VALID/OUT_READY/FLUSH over 10k cycles against a scoreboard queue -> no loss, duplication or reorder outside flush windows; OUT_DATA=0 whenever OUT_VALID=0.
